// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between decode/control and the OPq sequencer.
// master drives requests and accepts results; slave is the sequencer side.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 64
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic             set_cc;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] valE;
    logic             err;

    modport master (
        output req_valid, ifun, valA, valB, set_cc, res_ready,
        input  req_ready, res_valid, valE, err
    );

    modport slave (
        input  req_valid, ifun, valA, valB, set_cc, res_ready,
        output req_ready, res_valid, valE, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one Y86-64 OPq (addq/subq/andq/xorq) per request: IDLE -> EXEC -> DONE.
// Optional ALU_OPCOUNT_EN adds op_count, counting error-free completed handshakes.
module alu_op_sequencer #(
    parameter int unsigned WIDTH    = 64,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_sequencer_if.slave    bus,
    output logic [2:0]           cc,
    output logic                 busy
`ifdef ALU_OPCOUNT_EN
    ,
    output logic [31:0]          op_count
`endif
);
    localparam int unsigned Msb = WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e           state_q;
    logic [3:0]       ifun_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             set_cc_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_of;
    logic             alu_legal;

    // Y86 operand order: result is valB <op> valA.
    always_comb begin
        alu_res   = '0;
        alu_of    = 1'b0;
        alu_legal = 1'b1;
        case (ifun_q)
            4'd0: begin
                alu_res = b_q + a_q;
                alu_of  = (a_q[Msb] == b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
            end
            4'd1: begin
                alu_res = b_q - a_q;
                alu_of  = (a_q[Msb] != b_q[Msb]) && (alu_res[Msb] != b_q[Msb]);
            end
            4'd2:    alu_res = b_q & a_q;
            4'd3:    alu_res = b_q ^ a_q;
            default: alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ifun_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            set_cc_q      <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.valE      <= '0;
            bus.err       <= 1'b0;
            busy          <= 1'b0;
            cc            <= CC_RESET;
`ifdef ALU_OPCOUNT_EN
            op_count      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        ifun_q        <= bus.ifun;
                        a_q           <= bus.valA;
                        b_q           <= bus.valB;
                        set_cc_q      <= bus.set_cc;
                        state_q       <= StExec;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                StExec: begin
                    bus.valE      <= alu_res;
                    bus.err       <= !alu_legal;
                    bus.res_valid <= 1'b1;
                    state_q       <= StDone;
                    if (set_cc_q && alu_legal) begin
                        cc <= {(alu_res == '0), alu_res[Msb], alu_of};
                    end
                end
                StDone: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                        state_q       <= StIdle;
`ifdef ALU_OPCOUNT_EN
                        if (!bus.err) begin
                            op_count <= op_count + 32'd1;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer; expected values are hand-computed.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cc;
    logic        busy;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;
`ifdef ALU_OPCOUNT_EN
    logic [31:0] op_count;
`endif

    alu_op_sequencer_if #(.WIDTH(64)) bus ();

    alu_op_sequencer #(
        .WIDTH   (64),
        .CC_RESET(3'b100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .cc  (cc),
        .busy(busy)
`ifdef ALU_OPCOUNT_EN
        ,
        .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef ALU_OPCOUNT_EN
        check({tag, "_op_count"}, {32'd0, op_count}, {32'd0, exp_cnt});
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Full transaction: accept, EXEC, DONE with result checks, then handshake out.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [63:0] a,
                          input logic [63:0] b, input logic sc, input logic [63:0] exp_val,
                          input logic exp_err, input logic [2:0] exp_cc);
        check({tag, "_req_ready"}, {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.ifun      = f;
        bus.valA      = a;
        bus.valB      = b;
        bus.set_cc    = sc;
        step();
        bus.req_valid = 1'b0;
        check({tag, "_exec_res_valid"}, {63'd0, bus.res_valid}, 64'd0);
        check({tag, "_exec_busy"}, {63'd0, busy}, 64'd1);
        step();
        check({tag, "_res_valid"}, {63'd0, bus.res_valid}, 64'd1);
        check({tag, "_valE"}, bus.valE, exp_val);
        check({tag, "_err"}, {63'd0, bus.err}, {63'd0, exp_err});
        check({tag, "_cc"}, {61'd0, cc}, {61'd0, exp_cc});
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        if (!exp_err) exp_cnt++;
        check({tag, "_idle_res_valid"}, {63'd0, bus.res_valid}, 64'd0);
        check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        check_cnt(tag);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.ifun      = '0;
        bus.valA      = '0;
        bus.valB      = '0;
        bus.set_cc    = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        check("rst_valE", bus.valE, 64'd0);
        check("rst_err", {63'd0, bus.err}, 64'd0);
        check("rst_cc", {61'd0, cc}, 64'd4);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check_cnt("rst");

        // stray res_ready in IDLE must be ignored
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("stray_res_valid", {63'd0, bus.res_valid}, 64'd0);

        run_op("xor", 4'd3, 64'hCCCC_CCCC_CCCC_CCCC, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1,
               64'h6666_6666_6666_6666, 1'b0, 3'b000);
        run_op("sub_eq", 4'd1, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 3'b100);
        run_op("and_nocc", 4'd2, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b100);
        run_op("add_of", 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
               64'h8000_0000_0000_0000, 1'b0, 3'b011);
        run_op("illegal", 4'h7, 64'd9, 64'd9, 1'b1, 64'd0, 1'b1, 3'b011);
        run_op("sub_nocc", 4'd1, 64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b011);
        run_op("sub_of", 4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001);
        run_op("and_neg", 4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
               64'hF000_F000_F000_F000, 1'b0, 3'b010);

        // Backpressure: hold DONE for 5 cycles while a new request is offered.
        bus.req_valid = 1'b1;
        bus.ifun      = 4'd3;
        bus.valA      = 64'd0;
        bus.valB      = 64'h1234;
        bus.set_cc    = 1'b1;
        step();
        bus.ifun = 4'd0;
        bus.valA = 64'd7;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_res_valid", {63'd0, bus.res_valid}, 64'd1);
            check("stall_valE", bus.valE, 64'h1234);
            check("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
        end
        check("stall_cc", {61'd0, cc}, 64'd0);
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        exp_cnt++;
        check("stall_release_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("stall_release_busy", {63'd0, busy}, 64'd0);
        step();
        check("no_queue_busy", {63'd0, busy}, 64'd0);
        check_cnt("stall");

        // Reset during EXEC aborts the op and drops the result.
        bus.req_valid = 1'b1;
        bus.ifun      = 4'd0;
        bus.valA      = 64'd1;
        bus.valB      = 64'h7FFF_FFFF_FFFF_FFFF;
        bus.set_cc    = 1'b1;
        step();
        bus.req_valid = 1'b0;
        check("abort_in_exec", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        check("abort_res_valid", {63'd0, bus.res_valid}, 64'd0);
        check("abort_valE", bus.valE, 64'd0);
        check("abort_cc", {61'd0, cc}, 64'd4);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check_cnt("abort");
        step();
        check("abort_stays_idle", {63'd0, bus.res_valid}, 64'd0);

        run_op("post_rst_add", 4'd0, 64'd2, 64'd3, 1'b1, 64'd5, 1'b0, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
